// File: rtl/cv32e40p_trace_sched.sv
// In-order retirement scheduler for the instruction tracer: holds retired
// instructions until their late rd value arrives, then emits them in program order.
module cv32e40p_trace_sched #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,

  input  logic             issue_valid_i,
  output logic             issue_ready_o,
  input  logic [31:0]      issue_pc_i,
  input  logic [31:0]      issue_instr_i,
  input  logic [4:0]       issue_rd_i,
  input  logic [31:0]      issue_rd_wdata_i,
  output logic [TAG_W-1:0] issue_tag_o,

  input  logic             wb_valid_i,
  input  logic [TAG_W-1:0] wb_tag_i,
  input  logic [31:0]      wb_data_i,

  output logic             trace_valid_o,
  input  logic             trace_ready_i,
  output logic [31:0]      trace_pc_o,
  output logic [31:0]      trace_instr_o,
  output logic [4:0]       trace_rd_o,
  output logic [31:0]      trace_rd_wdata_o,
  output logic             trace_late_o,

  output logic [TAG_W:0]   count_o,
  output logic             wb_err_o
);

  typedef enum logic [1:0] {
    SLOT_FREE,
    SLOT_PEND,
    SLOT_DONE
  } slot_state_e;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_LOAD_FP = 7'b0000111;
  localparam logic [6:0] OPC_AMO     = 7'b0101111;
  localparam logic [6:0] OPC_OP_FP   = 7'b1010011;
  localparam logic [6:0] OPC_FMADD   = 7'b1000011;
  localparam logic [6:0] OPC_FMSUB   = 7'b1000111;
  localparam logic [6:0] OPC_FNMSUB  = 7'b1001011;
  localparam logic [6:0] OPC_FNMADD  = 7'b1001111;
  localparam logic [6:0] OPC_OP      = 7'b0110011;

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

  slot_state_e       state_q [DEPTH];
  logic [31:0]       pc_q    [DEPTH];
  logic [31:0]       instr_q [DEPTH];
  logic [4:0]        rd_q    [DEPTH];
  logic [31:0]       data_q  [DEPTH];
  logic              late_q  [DEPTH];

  logic [TAG_W-1:0]  wr_ptr_q;
  logic [TAG_W-1:0]  rd_ptr_q;
  logic [TAG_W:0]    count_q;
  logic              wb_err_q;

  logic              issue_late;
  logic              push;
  logic              pop;
  logic              wb_hit;

  // Destination values of loads, AMOs, divides and FP ops arrive after retirement.
  always_comb begin
    issue_late = 1'b0;
    case (issue_instr_i[6:0])
      OPC_LOAD, OPC_LOAD_FP, OPC_AMO,
      OPC_OP_FP, OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD: issue_late = 1'b1;
      OPC_OP: issue_late = (issue_instr_i[31:25] == 7'b0000001) && issue_instr_i[14];
      default: issue_late = 1'b0;
    endcase
    if (issue_rd_i == '0) begin
      issue_late = 1'b0;
    end
  end

  assign issue_ready_o = !rst_i && (count_q < FULL_CNT);
  assign push          = issue_valid_i && issue_ready_o;
  assign trace_valid_o = (state_q[rd_ptr_q] == SLOT_DONE);
  assign pop           = trace_valid_o && trace_ready_i;
  assign wb_hit        = wb_valid_i && (state_q[wb_tag_i] == SLOT_PEND);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= '{default: SLOT_FREE};
      pc_q     <= '{default: '0};
      instr_q  <= '{default: '0};
      rd_q     <= '{default: '0};
      data_q   <= '{default: '0};
      late_q   <= '{default: 1'b0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wb_err_q <= 1'b0;
    end else begin
      wb_err_q <= wb_valid_i && !wb_hit;

      // Writeback, pop and push always address distinct slots (PEND, DONE, FREE).
      if (wb_hit) begin
        state_q[wb_tag_i] <= SLOT_DONE;
        data_q[wb_tag_i]  <= wb_data_i;
        late_q[wb_tag_i]  <= 1'b1;
      end

      if (pop) begin
        state_q[rd_ptr_q] <= SLOT_FREE;
        rd_ptr_q          <= rd_ptr_q + TAG_W'(1);
      end

      if (push) begin
        state_q[wr_ptr_q] <= issue_late ? SLOT_PEND : SLOT_DONE;
        pc_q[wr_ptr_q]    <= issue_pc_i;
        instr_q[wr_ptr_q] <= issue_instr_i;
        rd_q[wr_ptr_q]    <= issue_rd_i;
        data_q[wr_ptr_q]  <= (issue_late || issue_rd_i == '0) ? '0 : issue_rd_wdata_i;
        late_q[wr_ptr_q]  <= 1'b0;
        wr_ptr_q          <= wr_ptr_q + TAG_W'(1);
      end

      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign issue_tag_o      = wr_ptr_q;
  assign count_o          = count_q;
  assign wb_err_o         = wb_err_q;
  assign trace_pc_o       = pc_q[rd_ptr_q];
  assign trace_instr_o    = instr_q[rd_ptr_q];
  assign trace_rd_o       = rd_q[rd_ptr_q];
  assign trace_rd_wdata_o = data_q[rd_ptr_q];
  assign trace_late_o     = late_q[rd_ptr_q];

endmodule

// File: tb/tb_cv32e40p_trace_sched.sv
// Bench for cv32e40p_trace_sched: directed scenarios plus random traffic, all
// checked against a record-queue reference model of the scheduler.
module tb_cv32e40p_trace_sched;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TW    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          issue_valid = 1'b0;
  logic          issue_ready;
  logic [31:0]   issue_pc = '0;
  logic [31:0]   issue_instr = '0;
  logic [4:0]    issue_rd = '0;
  logic [31:0]   issue_wdata = '0;
  logic [TW-1:0] issue_tag;
  logic          wb_valid = 1'b0;
  logic [TW-1:0] wb_tag = '0;
  logic [31:0]   wb_data = '0;
  logic          trace_valid;
  logic          trace_ready = 1'b0;
  logic [31:0]   trace_pc, trace_instr, trace_wdata;
  logic [4:0]    trace_rd;
  logic          trace_late;
  logic [TW:0]   count;
  logic          wb_err;

  cv32e40p_trace_sched #(.DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .issue_pc_i(issue_pc), .issue_instr_i(issue_instr), .issue_rd_i(issue_rd),
    .issue_rd_wdata_i(issue_wdata), .issue_tag_o(issue_tag),
    .wb_valid_i(wb_valid), .wb_tag_i(wb_tag), .wb_data_i(wb_data),
    .trace_valid_o(trace_valid), .trace_ready_i(trace_ready),
    .trace_pc_o(trace_pc), .trace_instr_o(trace_instr), .trace_rd_o(trace_rd),
    .trace_rd_wdata_o(trace_wdata), .trace_late_o(trace_late),
    .count_o(count), .wb_err_o(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned tag;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] data;
    bit          late;
    bit          done;
  } rec_t;

  rec_t        mq[$];
  int unsigned next_tag = 0;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [9:0] mid,
                                     input logic [2:0] f3, input logic [4:0] rd,
                                     input logic [6:0] op);
    return {f7, mid, f3, rd, op};
  endfunction

  // Reference rule: which retired instructions deliver their rd value later.
  function automatic bit is_late(input logic [31:0] ins, input logic [4:0] rd);
    logic [6:0] op;
    op = ins[6:0];
    if (rd == 5'd0) return 1'b0;
    if (op inside {7'h03, 7'h07, 7'h2F, 7'h53, 7'h43, 7'h47, 7'h4B, 7'h4F}) return 1'b1;
    if (op == 7'h33 && ins[31:25] == 7'd1 && ins[14:12] >= 3'd4) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check pre-edge outputs, advance model, check wb_err.
  task automatic cyc(input bit iv, input logic [31:0] pc, input logic [31:0] ins,
                     input logic [31:0] wd, input bit wv, input logic [TW-1:0] wt,
                     input logic [31:0] wdat, input bit rdy);
    bit   acc, pop, err, hd;
    int   widx;
    rec_t r;
    issue_valid = iv; issue_pc = pc; issue_instr = ins; issue_rd = ins[11:7];
    issue_wdata = wd; wb_valid = wv; wb_tag = wt; wb_data = wdat; trace_ready = rdy;
    #1;
    hd = (mq.size() > 0) && mq[0].done;
    check("issue_ready", 32'(issue_ready), 32'(mq.size() < DEPTH));
    check("issue_tag", 32'(issue_tag), next_tag);
    check("count", 32'(count), mq.size());
    check("trace_valid", 32'(trace_valid), 32'(hd));
    if (hd) begin
      check("trace_pc", trace_pc, mq[0].pc);
      check("trace_instr", trace_instr, mq[0].instr);
      check("trace_rd", 32'(trace_rd), 32'(mq[0].rd));
      check("trace_wdata", trace_wdata, mq[0].data);
      check("trace_late", 32'(trace_late), 32'(mq[0].late));
    end
    acc = iv && (mq.size() < DEPTH);
    pop = hd && rdy;
    widx = -1;
    err = 1'b0;
    if (wv) begin
      foreach (mq[i]) if (mq[i].tag == int'(wt) && !mq[i].done) widx = i;
      err = (widx < 0);
    end
    @(posedge clk);
    #1;
    if (widx >= 0) begin
      mq[widx].done = 1'b1;
      mq[widx].data = wdat;
      mq[widx].late = 1'b1;
    end
    if (pop) void'(mq.pop_front());
    if (acc) begin
      r.tag = next_tag; r.pc = pc; r.instr = ins; r.rd = ins[11:7];
      r.late = 1'b0;
      r.done = !is_late(ins, ins[11:7]);
      r.data = (r.done && r.rd != 5'd0) ? wd : 32'd0;
      mq.push_back(r);
      next_tag = (next_tag + 1) % DEPTH;
    end
    check("wb_err", 32'(wb_err), 32'(err));
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] wd, input bit rdy);
    cyc(1'b1, pc, ins, wd, 1'b0, '0, '0, rdy);
  endtask

  task automatic wb(input logic [TW-1:0] t, input logic [31:0] d, input bit rdy);
    cyc(1'b0, '0, '0, '0, 1'b1, t, d, rdy);
  endtask

  task automatic idle(input bit rdy);
    cyc(1'b0, '0, '0, '0, 1'b0, '0, '0, rdy);
  endtask

  // Asynchronous reset pulse away from the clock edge; state must clear at once.
  task automatic hard_reset();
    issue_valid = 1'b0; wb_valid = 1'b0; trace_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    mq.delete();
    next_tag = 0;
    check("rst_valid", 32'(trace_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ready", 32'(issue_ready), 32'd0);
    check("rst_tag", 32'(issue_tag), 32'd0);
    check("rst_wb_err", 32'(wb_err), 32'd0);
    check("rst_pc", trace_pc, 32'd0);
    check("rst_instr", trace_instr, 32'd0);
    check("rst_wdata", trace_wdata, 32'd0);
    check("rst_rd", 32'(trace_rd), 32'd0);
    check("rst_late", 32'(trace_late), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10];
    logic [6:0] f7;
    logic [4:0] rd;
    ops = '{7'h03, 7'h07, 7'h2F, 7'h53, 7'h43, 7'h47, 7'h4B, 7'h4F, 7'h33, 7'h13};
    f7 = ($urandom_range(0, 1) == 1) ? 7'd1 : 7'($urandom);
    rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    return mk(f7, 10'($urandom), 3'($urandom), rd, ops[$urandom_range(0, 9)]);
  endfunction

  logic [31:0] lw6, add7, lw0, addi5, div1, fdiv2, rem3;
  int unsigned pend_tags[$];
  bit          r_iv, r_wv, r_rdy;
  logic [TW-1:0] r_wt;

  initial begin
    lw6   = mk(7'd0, 10'd0, 3'b010, 5'd6, 7'h03);
    add7  = mk(7'd0, 10'd0, 3'b000, 5'd7, 7'h33);
    lw0   = mk(7'd0, 10'd0, 3'b010, 5'd0, 7'h03);
    addi5 = 32'h00500293;
    div1  = mk(7'd1, 10'd0, 3'b100, 5'd1, 7'h33);
    fdiv2 = mk(7'b0001100, 10'd0, 3'b000, 5'd2, 7'h53);
    rem3  = mk(7'd1, 10'd0, 3'b110, 5'd3, 7'h33);

    hard_reset();

    // Single non-late instruction
    issue(32'h80, addi5, 32'd5, 1'b0);
    check("addi_valid", 32'(trace_valid), 32'd1);
    check("addi_data", trace_wdata, 32'd5);
    idle(1'b1);
    idle(1'b0);

    // In-order blocking behind a pending load
    hard_reset();
    issue(32'h100, lw6, 32'h77, 1'b0);
    issue(32'h104, add7, 32'h11, 1'b1);
    idle(1'b1);
    idle(1'b1);
    wb(2'd0, 32'hDEAD, 1'b0);
    check("lw_data", trace_wdata, 32'hDEAD);
    check("lw_late", 32'(trace_late), 32'd1);
    idle(1'b1);
    check("add_data", trace_wdata, 32'h11);
    idle(1'b1);
    idle(1'b0);

    // Out-of-order writebacks
    hard_reset();
    issue(32'h200, div1, 32'h99, 1'b0);
    issue(32'h204, fdiv2, 32'h99, 1'b0);
    issue(32'h208, rem3, 32'h99, 1'b0);
    wb(2'd2, 32'h33, 1'b1);
    wb(2'd0, 32'h11, 1'b1);
    wb(2'd1, 32'h22, 1'b1);
    repeat (3) idle(1'b1);

    // Full and wrap
    hard_reset();
    for (int i = 0; i < 4; i++) issue(32'h300 + 4 * i, lw6, 32'h0, 1'b0);
    issue(32'h310, addi5, 32'h5, 1'b0);
    check("full_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) wb(2'(i), 32'hA0 + i, 1'b0);
    issue(32'h314, addi5, 32'h5, 1'b1);
    repeat (3) idle(1'b1);
    for (int i = 0; i < 6; i++) issue(32'h400 + 4 * i, addi5, 32'h50 + i, 1'b1);
    repeat (2) idle(1'b1);

    // Error pulse and rd=0
    hard_reset();
    wb(2'd2, 32'h1234, 1'b0);
    idle(1'b0);
    issue(32'h500, lw0, 32'hFFFF, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // Reset mid-operation
    hard_reset();
    issue(32'h600, addi5, 32'h5, 1'b0);
    issue(32'h604, lw6, 32'h0, 1'b0);
    issue(32'h608, add7, 32'h7, 1'b0);
    hard_reset();
    wb(2'd1, 32'hBEEF, 1'b1);
    idle(1'b1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) hard_reset();
      pend_tags.delete();
      foreach (mq[i]) if (!mq[i].done) pend_tags.push_back(mq[i].tag);
      r_iv  = ($urandom_range(0, 99) < 60);
      r_wv  = ($urandom_range(0, 99) < 45);
      r_rdy = ($urandom_range(0, 99) < 65);
      if (pend_tags.size() > 0 && $urandom_range(0, 9) < 8)
        r_wt = TW'(pend_tags[$urandom_range(0, pend_tags.size() - 1)]);
      else
        r_wt = TW'($urandom);
      cyc(r_iv, $urandom, rand_instr(), $urandom, r_wv, r_wt, $urandom, r_rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
